// File: rtl/initial_shift_scheduler_if.sv
// Command, memory-port and processor-operand bundle between the polymult controller,
// the normal/accumulator BRAMs, initial_shift_processor and the initial-shift scheduler.
interface initial_shift_scheduler_if #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [15:0]           cmd_shift;
    logic [5:0]            cmd_shift_idx;

    logic                  n_rd_en;
    logic [ADDR_WIDTH-1:0] n_rd_addr;
    logic [WORD_WIDTH-1:0] n_rd_data;

    logic                  a_rd_en;
    logic [ADDR_WIDTH-1:0] a_rd_addr;
    logic [WORD_WIDTH-1:0] a_rd_data;
    logic                  a_wr_en;
    logic [ADDR_WIDTH-1:0] a_wr_addr;
    logic [WORD_WIDTH-1:0] a_wr_data;

    logic [WORD_WIDTH-1:0] proc_word_zero;
    logic [WORD_WIDTH-1:0] proc_word_551;
    logic [WORD_WIDTH-1:0] proc_word_552;
    logic [WORD_WIDTH-1:0] proc_acc_word;
    logic [15:0]           proc_shift;
    logic [5:0]            proc_shift_idx;
    logic                  proc_start;
    logic [WORD_WIDTH-1:0] proc_result;
    logic                  proc_done;

    logic                  done;
    logic                  err;

    modport master (
        output cmd_valid, cmd_shift, cmd_shift_idx, n_rd_data, a_rd_data, proc_result, proc_done,
        input  cmd_ready, n_rd_en, n_rd_addr, a_rd_en, a_rd_addr, a_wr_en, a_wr_addr, a_wr_data,
               proc_word_zero, proc_word_551, proc_word_552, proc_acc_word, proc_shift,
               proc_shift_idx, proc_start, done, err
    );

    modport slave (
        input  cmd_valid, cmd_shift, cmd_shift_idx, n_rd_data, a_rd_data, proc_result, proc_done,
        output cmd_ready, n_rd_en, n_rd_addr, a_rd_en, a_rd_addr, a_wr_en, a_wr_addr, a_wr_data,
               proc_word_zero, proc_word_551, proc_word_552, proc_acc_word, proc_shift,
               proc_shift_idx, proc_start, done, err
    );
endinterface

// File: rtl/initial_shift_scheduler.sv
// Sequences one initial-shift job: fetch normal words 0/551/552 and the target accumulator
// word, run initial_shift_processor, write the result back and report done/err.
module initial_shift_scheduler #(
    parameter int unsigned WORD_WIDTH    = 32,
    parameter int unsigned ADDR_WIDTH    = 10,
    parameter int unsigned NUM_ACC_WORDS = 553,
    parameter int unsigned TIMEOUT_CYC   = 15
) (
    input logic                      clk,
    input logic                      rst,
    initial_shift_scheduler_if.slave bus
);
    localparam int unsigned IDX_W = 11;
    localparam int unsigned CNT_W = 5;
    localparam logic [ADDR_WIDTH-1:0] ADDR_551 = ADDR_WIDTH'(551);
    localparam logic [ADDR_WIDTH-1:0] ADDR_552 = ADDR_WIDTH'(552);

    typedef enum logic [3:0] {
        S_IDLE, S_RD0, S_RD551, S_RD552, S_RDACC, S_START, S_WAIT, S_WB, S_DONE, S_ERR_DONE
    } state_t;

    state_t state, state_nx;

    logic [IDX_W-1:0]      cmd_idx_c;
    logic                  accept_c;
    logic                  timeout_c;
    logic [CNT_W-1:0]      tmo_cnt;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [15:0]           shift_q;
    logic [5:0]            shift_idx_q;
    logic [WORD_WIDTH-1:0] word_zero_q, word_551_q, word_552_q, acc_word_q, result_q;

    logic                  cmd_ready_d, n_rd_en_d, a_rd_en_d, a_wr_en_d, proc_start_d, done_d, err_d;
    logic [ADDR_WIDTH-1:0] n_rd_addr_d;
    logic                  cmd_ready_q, n_rd_en_q, a_rd_en_q, a_wr_en_q, proc_start_q, done_q, err_q;
    logic [ADDR_WIDTH-1:0] n_rd_addr_q;

    // Range check uses the full 11-bit index so large shifts cannot alias into range
    assign cmd_idx_c = bus.cmd_shift[15:5];
    assign accept_c  = (state == S_IDLE) && bus.cmd_valid;
    // The counter reaches TIMEOUT_CYC on the 16th WAIT cycle; proc_done still wins there
    assign timeout_c = (tmo_cnt == CNT_W'(TIMEOUT_CYC));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:     if (accept_c)
                            state_nx = (cmd_idx_c >= IDX_W'(NUM_ACC_WORDS)) ? S_ERR_DONE : S_RD0;
            S_RD0:      state_nx = S_RD551;
            S_RD551:    state_nx = S_RD552;
            S_RD552:    state_nx = S_RDACC;
            S_RDACC:    state_nx = S_START;
            S_START:    state_nx = S_WAIT;
            S_WAIT:     if (bus.proc_done) state_nx = S_WB;
                        else if (timeout_c) state_nx = S_ERR_DONE;
            S_WB:       state_nx = S_DONE;
            S_DONE:     state_nx = S_IDLE;
            S_ERR_DONE: state_nx = S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they register in step with the state
    always_comb begin
        cmd_ready_d  = 1'b0;
        n_rd_en_d    = 1'b0;
        n_rd_addr_d  = '0;
        a_rd_en_d    = 1'b0;
        a_wr_en_d    = 1'b0;
        proc_start_d = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        case (state_nx)
            S_IDLE:     cmd_ready_d = 1'b1;
            S_RD0:      n_rd_en_d = 1'b1;
            S_RD551:    begin n_rd_en_d = 1'b1; n_rd_addr_d = ADDR_551; end
            S_RD552:    begin n_rd_en_d = 1'b1; n_rd_addr_d = ADDR_552; end
            S_RDACC:    a_rd_en_d = 1'b1;
            S_START:    proc_start_d = 1'b1;
            S_WB:       a_wr_en_d = 1'b1;
            S_DONE:     done_d = 1'b1;
            S_ERR_DONE: begin done_d = 1'b1; err_d = 1'b1; end
            default:    ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_ready_q  <= 1'b1;
            n_rd_en_q    <= 1'b0;
            n_rd_addr_q  <= '0;
            a_rd_en_q    <= 1'b0;
            a_wr_en_q    <= 1'b0;
            proc_start_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            cmd_ready_q  <= cmd_ready_d;
            n_rd_en_q    <= n_rd_en_d;
            n_rd_addr_q  <= n_rd_addr_d;
            a_rd_en_q    <= a_rd_en_d;
            a_wr_en_q    <= a_wr_en_d;
            proc_start_q <= proc_start_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // Command latch, operand capture (1-cycle read latency) and WAIT timeout counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q     <= '0;
            shift_idx_q <= '0;
            idx_q       <= '0;
            word_zero_q <= '0;
            word_551_q  <= '0;
            word_552_q  <= '0;
            acc_word_q  <= '0;
            result_q    <= '0;
            tmo_cnt     <= '0;
        end else begin
            if (accept_c) begin
                shift_q     <= bus.cmd_shift;
                shift_idx_q <= bus.cmd_shift_idx;
                idx_q       <= ADDR_WIDTH'(cmd_idx_c);
            end
            case (state)
                S_RD551: word_zero_q <= bus.n_rd_data;
                S_RD552: word_551_q  <= bus.n_rd_data;
                S_RDACC: word_552_q  <= bus.n_rd_data;
                S_START: begin
                    acc_word_q <= bus.a_rd_data;
                    tmo_cnt    <= '0;
                end
                S_WAIT: begin
                    if (bus.proc_done)  result_q <= bus.proc_result;
                    else if (!timeout_c) tmo_cnt <= tmo_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready      = cmd_ready_q;
    assign bus.n_rd_en        = n_rd_en_q;
    assign bus.n_rd_addr      = n_rd_addr_q;
    assign bus.a_rd_en        = a_rd_en_q;
    assign bus.a_rd_addr      = idx_q;
    assign bus.a_wr_en        = a_wr_en_q;
    assign bus.a_wr_addr      = idx_q;
    assign bus.a_wr_data      = result_q;
    assign bus.proc_word_zero = word_zero_q;
    assign bus.proc_word_551  = word_551_q;
    assign bus.proc_word_552  = word_552_q;
    assign bus.proc_acc_word  = acc_word_q;
    assign bus.proc_shift     = shift_q;
    assign bus.proc_shift_idx = shift_idx_q;
    assign bus.proc_start     = proc_start_q;
    assign bus.done           = done_q;
    assign bus.err            = err_q;
endmodule

// File: tb/tb_initial_shift_scheduler.sv
// Bench for initial_shift_scheduler: memory and processor models, a vector table of jobs
// with hand-computed cycle timings, and hand-written back-to-back and mid-job reset sequences.
`timescale 1ns/1ps
module tb_initial_shift_scheduler;
    localparam int unsigned WW = 32;
    localparam int unsigned AW = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    initial_shift_scheduler_if #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW)) bus ();

    initial_shift_scheduler #(
        .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .NUM_ACC_WORDS(553), .TIMEOUT_CYC(15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [WW-1:0] nval(input int i);
        return 32'h9000_0000 + 32'(i) * 32'h0001_0003;
    endfunction

    function automatic logic [WW-1:0] aval(input int i);
        return 32'hC0DE_0005 ^ (32'(i) << 4);
    endfunction

    // Memory models: 1-cycle read latency, accumulator writes counted
    logic [WW-1:0] amem [0:1023];
    logic          mem_init;
    int            wr_count;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) amem[i] <= aval(i);
            wr_count <= 0;
        end else if (bus.a_wr_en) begin
            amem[bus.a_wr_addr] <= bus.a_wr_data;
            wr_count <= wr_count + 1;
        end
        if (bus.a_rd_en) bus.a_rd_data <= amem[bus.a_rd_addr];
        if (bus.n_rd_en) bus.n_rd_data <= nval(int'(bus.n_rd_addr));
    end

    // Processor model: mode 0 answers 3 cycles after start, other modes stay silent
    int   proc_mode;
    int   pcnt     = 0;
    logic mdl_done = 1'b0;
    logic inj_done;
    always @(posedge clk) begin
        mdl_done <= 1'b0;
        if (bus.proc_start && proc_mode == 0) pcnt <= 3;
        else if (pcnt != 0) begin
            pcnt <= pcnt - 1;
            if (pcnt == 2) mdl_done <= 1'b1;
        end
    end
    assign bus.proc_done   = mdl_done | inj_done;
    assign bus.proc_result = bus.proc_acc_word ^ bus.proc_word_zero ^ bus.proc_word_551
                           ^ bus.proc_word_552 ^ 32'(bus.proc_shift);

    logic [WW-1:0] exp_acc [0:1023];

    function automatic logic [WW-1:0] exp_result(input logic [WW-1:0] acc, input logic [15:0] shift);
        return acc ^ nval(0) ^ nval(551) ^ nval(552) ^ 32'(shift);
    endfunction

    typedef struct {
        logic [15:0] shift;
        logic [5:0]  sidx;
        int          mode;       // 0 normal, 1 silent, 2 done injected in cycle 21
        int          busy_cyc;   // 0 = no busy pulse
        logic [15:0] busy_shift;
        logic        exp_err;
        int          exp_done;
        int          exp_start;  // 0 = never
        int          exp_wr;     // 0 = never
        int          exp_nrd;
        int          exp_ard;
    } vec_t;

    vec_t vecs [9];

    task automatic run_vec(input int k, input vec_t v);
        int c, done_c, start_c, wr_c, nrd, ard, idx, w0;
        logic err_s;
        logic [AW-1:0] wr_a, ard_a;
        logic [WW-1:0] wr_d, exp_d, acc0;
        logic [AW-1:0] nra [$];
        string p;
        p = $sformatf("v%0d", k);
        done_c = 0; start_c = 0; wr_c = 0; nrd = 0; ard = 0; err_s = 1'b0;
        wr_a = '0; ard_a = '0; wr_d = '0;
        idx = int'(v.shift[15:5]);
        acc0 = (idx < 1024) ? exp_acc[idx] : '0;
        exp_d = exp_result(acc0, v.shift);
        w0 = wr_count;
        proc_mode = v.mode;
        bus.cmd_shift = v.shift;
        bus.cmd_shift_idx = v.sidx;
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        c = 1;
        while (c <= 60) begin
            if (bus.n_rd_en) begin nrd++; nra.push_back(bus.n_rd_addr); end
            if (bus.a_rd_en) begin ard++; ard_a = bus.a_rd_addr; end
            if (bus.proc_start && start_c == 0) start_c = c;
            if (bus.a_wr_en) begin wr_c = c; wr_a = bus.a_wr_addr; wr_d = bus.a_wr_data; end
            bus.cmd_valid = (c == v.busy_cyc);
            if (c == v.busy_cyc) bus.cmd_shift = v.busy_shift;
            inj_done = (v.mode == 2 && c == 21);
            if (bus.done) begin done_c = c; err_s = bus.err; break; end
            @(posedge clk); #1;
            c++;
        end
        bus.cmd_valid = 1'b0;
        inj_done = 1'b0;
        chk({p, " done_cycle"}, 32'(done_c), 32'(v.exp_done));
        chk({p, " err"}, 32'(err_s), 32'(v.exp_err));
        chk({p, " start_cycle"}, 32'(start_c), 32'(v.exp_start));
        chk({p, " wr_cycle"}, 32'(wr_c), 32'(v.exp_wr));
        chk({p, " n_rd_count"}, 32'(nrd), 32'(v.exp_nrd));
        chk({p, " a_rd_count"}, 32'(ard), 32'(v.exp_ard));
        chk({p, " proc_shift"}, 32'(bus.proc_shift), 32'(v.shift));
        chk({p, " proc_shift_idx"}, 32'(bus.proc_shift_idx), 32'(v.sidx));
        if (nra.size() == 3) begin
            chk({p, " n_rd_addr0"}, 32'(nra[0]), 32'd0);
            chk({p, " n_rd_addr1"}, 32'(nra[1]), 32'd551);
            chk({p, " n_rd_addr2"}, 32'(nra[2]), 32'd552);
            chk({p, " word_zero"}, bus.proc_word_zero, nval(0));
            chk({p, " word_551"}, bus.proc_word_551, nval(551));
            chk({p, " word_552"}, bus.proc_word_552, nval(552));
            chk({p, " acc_word"}, bus.proc_acc_word, acc0);
        end
        if (ard != 0) chk({p, " a_rd_addr"}, 32'(ard_a), 32'(idx));
        if (v.exp_wr != 0) begin
            chk({p, " wr_addr"}, 32'(wr_a), 32'(idx));
            chk({p, " wr_data"}, wr_d, exp_d);
            exp_acc[idx] = exp_d;
        end
        if (idx < 1024) chk({p, " acc_mem"}, amem[idx], exp_acc[idx]);
        chk({p, " wr_count"}, 32'(wr_count - w0), (v.exp_wr != 0) ? 32'd1 : 32'd0);
        @(posedge clk); #1;
        chk({p, " ready_after"}, {31'd0, bus.cmd_ready}, 32'd1);
        chk({p, " done_pulse"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, second_c, dones, w0;
        logic [WW-1:0] e0, e552;

        vecs[0] = '{16'h0047, 6'd7,  0, 0, 16'h0000, 1'b0, 10, 5, 9,  3, 1};
        vecs[1] = '{16'hFFFF, 6'd3,  0, 0, 16'h0000, 1'b1, 1,  0, 0,  0, 0};
        vecs[2] = '{16'h0000, 6'd0,  0, 0, 16'h0000, 1'b0, 10, 5, 9,  3, 1};
        vecs[3] = '{16'h4500, 6'd63, 0, 0, 16'h0000, 1'b0, 10, 5, 9,  3, 1};
        vecs[4] = '{16'h4520, 6'd1,  0, 0, 16'h0000, 1'b1, 1,  0, 0,  0, 0};
        vecs[5] = '{16'h8000, 6'd1,  0, 0, 16'h0000, 1'b1, 1,  0, 0,  0, 0};
        vecs[6] = '{16'h0021, 6'd5,  1, 0, 16'h0000, 1'b1, 22, 5, 0,  3, 1};
        vecs[7] = '{16'h0047, 6'd7,  0, 4, 16'h0021, 1'b0, 10, 5, 9,  3, 1};
        vecs[8] = '{16'h0040, 6'd9,  2, 0, 16'h0000, 1'b0, 23, 5, 22, 3, 1};

        for (int i = 0; i < 1024; i++) exp_acc[i] = aval(i);

        rst = 1'b1;
        mem_init = 1'b1;
        inj_done = 1'b0;
        proc_mode = 0;
        bus.cmd_valid = 1'b0;
        bus.cmd_shift = '0;
        bus.cmd_shift_idx = '0;
        repeat (2) @(posedge clk);
        #1;
        mem_init = 1'b0;
        chk("reset strobes", {25'd0, bus.cmd_ready, bus.n_rd_en, bus.a_rd_en, bus.a_wr_en,
                              bus.proc_start, bus.done, bus.err}, 32'h40);
        chk("reset proc_shift", 32'(bus.proc_shift), 32'd0);
        chk("reset word_zero", bus.proc_word_zero, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < 9; k++) run_vec(k, vecs[k]);

        // Back-to-back: valid held high, second command accepted once ready returns
        proc_mode = 0;
        w0 = wr_count;
        e0   = exp_result(exp_acc[0], 16'h0000);
        e552 = exp_result(exp_acc[552], 16'h4500);
        bus.cmd_shift = 16'h0000;
        bus.cmd_shift_idx = 6'd1;
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_shift = 16'h4500;
        c = 1; second_c = 0; dones = 0;
        while (c <= 40 && dones < 2) begin
            if (bus.done) dones++;
            if (bus.cmd_ready && bus.cmd_valid) second_c = c;
            @(posedge clk); #1;
            c++;
            if (second_c != 0) bus.cmd_valid = 1'b0;
        end
        bus.cmd_valid = 1'b0;
        exp_acc[0] = e0;
        exp_acc[552] = e552;
        chk("b2b second_accept_cycle", 32'(second_c), 32'd11);
        chk("b2b done_count", 32'(dones), 32'd2);
        chk("b2b wr_count", 32'(wr_count - w0), 32'd2);
        chk("b2b acc0", amem[0], e0);
        chk("b2b acc552", amem[552], e552);
        repeat (2) @(posedge clk);
        #1;

        // Reset asserted mid-cycle while waiting on the processor
        w0 = wr_count;
        bus.cmd_shift = 16'h0021;
        bus.cmd_shift_idx = 6'd4;
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_mid strobes", {25'd0, bus.cmd_ready, bus.n_rd_en, bus.a_rd_en, bus.a_wr_en,
                                bus.proc_start, bus.done, bus.err}, 32'h40);
        @(posedge clk); #1;
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done || bus.a_wr_en) dones++;
            @(posedge clk); #1;
        end
        chk("rst_mid no_done_or_write", 32'(dones), 32'd0);
        chk("rst_mid wr_count", 32'(wr_count - w0), 32'd0);
        chk("rst_mid acc1", amem[1], exp_acc[1]);
        chk("rst_mid ready", {31'd0, bus.cmd_ready}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
